// File: rtl/histogram_kontrol.sv
// Frame histogram-equalisation sequencer: clear, count, CDF, LUT build and remap over one shared 256-bin RAM.
// Optional `HISTOGRAM_KONTROL_STATS_EN adds cdf_min_o and run_cycles observation ports.
module histogram_kontrol #(
    parameter int N_PIXELS = 76800,
    parameter int PIX_W    = 8,
    parameter int CNT_W    = 17
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           phase,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PIX_W-1:0]     in_pix,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PIX_W-1:0]     out_pix,
    output logic                 div_req,
    output logic [CNT_W+7:0]     div_num,
    output logic [CNT_W-1:0]     div_den,
    input  logic                 div_ack,
    input  logic [PIX_W-1:0]     div_quot
`ifdef HISTOGRAM_KONTROL_STATS_EN
    ,
    output logic [CNT_W-1:0]     cdf_min_o,
    output logic [31:0]          run_cycles
`endif
);

    localparam int BINS = 2 ** PIX_W;
    localparam logic [PIX_W-1:0] K_LAST  = '1;
    localparam logic [CNT_W-1:0] N_TOTAL = CNT_W'(N_PIXELS);
    localparam logic [CNT_W-1:0] N_LAST  = CNT_W'(N_PIXELS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        COUNT = 3'd2,
        CDF   = 3'd3,
        LUT   = 3'd4,
        REMAP = 3'd5,
        DONE  = 3'd6
    } phase_t;

    // Bins below cdf_min give a negative numerator; clamp those to zero.
    function automatic logic [CNT_W+7:0] lut_num(input logic [CNT_W-1:0] cdf,
                                                 input logic [CNT_W-1:0] cmin);
        if (cdf <= cmin) return '0;
        return (CNT_W+8)'(cdf - cmin) * (CNT_W+8)'(255);
    endfunction

    phase_t               phase_q;
    logic [PIX_W-1:0]     k_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     ocnt_q;
    logic [CNT_W-1:0]     run_q;
    logic [CNT_W-1:0]     cdf_min_q;
    logic                 found_q;
    logic                 div_req_q;
    logic [CNT_W+7:0]     div_num_q;
    logic [CNT_W-1:0]     div_den_q;
    logic                 out_valid_q;
    logic [PIX_W-1:0]     out_pix_q;
    logic                 done_q;

    logic [CNT_W-1:0]     bin_mem [BINS];
    logic [CNT_W-1:0]     rd_k;
    logic [CNT_W-1:0]     rd_pix;
    logic [CNT_W-1:0]     cdf_sum;
    logic                 den_zero;
    logic                 in_rdy;
    logic                 in_acc;
    logic                 out_acc;
    logic                 mem_we;
    logic [PIX_W-1:0]     mem_wa;
    logic [CNT_W-1:0]     mem_wd;

    assign rd_k     = bin_mem[k_q];
    assign rd_pix   = bin_mem[in_pix];
    assign cdf_sum  = run_q + rd_k;
    assign den_zero = (div_den_q == '0);
    assign in_rdy   = (phase_q == COUNT) ||
                      ((phase_q == REMAP) && (cnt_q != N_TOTAL) && (!out_valid_q || out_ready));
    assign in_acc   = in_valid && in_rdy;
    assign out_acc  = out_valid_q && out_ready;

    assign busy      = (phase_q != IDLE);
    assign done      = done_q;
    assign phase     = phase_q;
    assign in_ready  = in_rdy;
    assign out_valid = out_valid_q;
    assign out_pix   = out_pix_q;
    assign div_req   = div_req_q;
    assign div_num   = div_num_q;
    assign div_den   = div_den_q;

    // Single RAM write port; the read-modify-write in COUNT completes within one
    // cycle, so back-to-back equal pixels always see the previous increment.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = k_q;
        mem_wd = '0;
        case (phase_q)
            CLEAR: mem_we = 1'b1;
            COUNT: begin
                mem_we = in_acc;
                mem_wa = in_pix;
                mem_wd = rd_pix + 1'b1;
            end
            CDF: begin
                mem_we = 1'b1;
                mem_wd = cdf_sum;
            end
            LUT: begin
                mem_we = den_zero || (div_req_q && div_ack);
                mem_wd = den_zero ? '0 : CNT_W'(div_quot);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) bin_mem[mem_wa] <= mem_wd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q     <= IDLE;
            k_q         <= '0;
            cnt_q       <= '0;
            ocnt_q      <= '0;
            run_q       <= '0;
            cdf_min_q   <= '0;
            found_q     <= 1'b0;
            div_req_q   <= 1'b0;
            div_num_q   <= '0;
            div_den_q   <= '0;
            out_valid_q <= 1'b0;
            out_pix_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (phase_q)
                IDLE: begin
                    if (start) begin
                        phase_q   <= CLEAR;
                        k_q       <= '0;
                        cnt_q     <= '0;
                        ocnt_q    <= '0;
                        run_q     <= '0;
                        cdf_min_q <= '0;
                        found_q   <= 1'b0;
                        div_num_q <= '0;
                        div_den_q <= '0;
                    end
                end
                CLEAR: begin
                    k_q <= k_q + 1'b1;
                    if (k_q == K_LAST) phase_q <= COUNT;
                end
                COUNT: begin
                    if (in_acc) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == N_LAST) begin
                            cnt_q   <= '0;
                            phase_q <= CDF;
                        end
                    end
                end
                CDF: begin
                    run_q <= cdf_sum;
                    k_q   <= k_q + 1'b1;
                    if (!found_q && (cdf_sum != '0)) begin
                        found_q   <= 1'b1;
                        cdf_min_q <= cdf_sum;
                    end
                    if (k_q == K_LAST) begin
                        phase_q   <= LUT;
                        div_den_q <= N_TOTAL - (found_q ? cdf_min_q : cdf_sum);
                    end
                end
                LUT: begin
                    if (den_zero) begin
                        k_q <= k_q + 1'b1;
                        if (k_q == K_LAST) phase_q <= REMAP;
                    end else if (!div_req_q) begin
                        div_req_q <= 1'b1;
                        div_num_q <= lut_num(rd_k, cdf_min_q);
                    end else if (div_ack) begin
                        div_req_q <= 1'b0;
                        k_q       <= k_q + 1'b1;
                        if (k_q == K_LAST) phase_q <= REMAP;
                    end
                end
                REMAP: begin
                    if (in_acc) begin
                        out_pix_q   <= rd_pix[PIX_W-1:0];
                        out_valid_q <= 1'b1;
                        cnt_q       <= cnt_q + 1'b1;
                    end else if (out_acc) begin
                        out_valid_q <= 1'b0;
                    end
                    if (out_acc) begin
                        ocnt_q <= ocnt_q + 1'b1;
                        if (ocnt_q == N_LAST) begin
                            phase_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DONE:    phase_q <= IDLE;
                default: phase_q <= IDLE;
            endcase
        end
    end

`ifdef HISTOGRAM_KONTROL_STATS_EN
    logic [31:0] run_cyc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            run_cyc_q <= '0;
        end else if ((phase_q == IDLE) && start) begin
            run_cyc_q <= 32'd1;
        end else if (phase_q != IDLE) begin
            run_cyc_q <= run_cyc_q + 32'd1;
        end
    end

    assign cdf_min_o  = cdf_min_q;
    assign run_cycles = run_cyc_q;
`endif

endmodule
